id_stage_pipe: RTL and testbench

ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

---
 rtl/id_stage_pipe.sv | 159 +++++++++++++++
 tb/tb_id_stage_pipe.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: instruction decode stage with register file, one-entry
// registered output bundle, load-use interlock and flush.
// Optional feature: define ID_WB_BYPASS_EN so that an operand read of a
// register being written in the same cycle returns the write data.
module id_stage_pipe #(
   parameter int ARQ   = 16,
   parameter int NREGS = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [ARQ-1:0]             instr,
   input  logic                       wb_we,
   input  logic [$clog2(NREGS)-1:0]   wb_addr,
   input  logic [ARQ-1:0]             wb_data,
   input  logic                       flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [ARQ-1:0]             out_a,
   output logic [ARQ-1:0]             out_b,
   output logic [ARQ-1:0]             out_imm,
   output logic [ARQ-5:0]             out_addr,
   output logic [$clog2(NREGS)-1:0]   out_rd,
   output logic                       rd_mem_en,
   output logic                       wr_mem_en,
   output logic                       mux_exe,
   output logic                       mux_mem,
   output logic                       jenable,
   output logic                       jop_lsb,
   output logic                       wb_enable,
   output logic [1:0]                 alu_op
);
   localparam int RW   = $clog2(NREGS);
   localparam int IMMW = ARQ - 4 - RW;
   localparam int AW   = ARQ - 4;

   localparam logic [3:0] OP_SET = 4'd0;
   localparam logic [3:0] OP_ADD = 4'd1;
   localparam logic [3:0] OP_SUB = 4'd2;
   localparam logic [3:0] OP_CMP = 4'd3;
   localparam logic [3:0] OP_LD  = 4'd4;
   localparam logic [3:0] OP_ST  = 4'd5;
   localparam logic [3:0] OP_JEQ = 4'd6;
   localparam logic [3:0] OP_J   = 4'd7;

   // Control vector order: rd_mem, wr_mem, mux_exe, mux_mem, jen, jlsb, wb, alu[1:0]
   logic [3:0]     w_op;
   logic [RW-1:0]  w_rd;
   logic [RW-1:0]  w_rs1;
   logic [RW-1:0]  w_rs2;
   logic [ARQ-1:0] w_imm;
   logic [AW-1:0]  w_addr;
   logic [ARQ-1:0] w_rs1_val;
   logic [ARQ-1:0] w_rs2_val;
   logic [8:0]     w_ctl;
   logic           w_reads_rs1;
   logic           w_reads_rs2;
   logic           w_hazard;
   logic           w_take;

   logic [ARQ-1:0] r_regs [NREGS];
   logic           r_valid;
   logic           r_is_ld;
   logic [ARQ-1:0] r_a;
   logic [ARQ-1:0] r_b;
   logic [ARQ-1:0] r_imm;
   logic [AW-1:0]  r_addr;
   logic [RW-1:0]  r_rd;
   logic [8:0]     r_ctl;

   assign w_op   = instr[ARQ-1 -: 4];
   assign w_rd   = instr[ARQ-5 -: RW];
   assign w_rs1  = instr[ARQ-5-RW -: RW];
   assign w_rs2  = instr[ARQ-5-2*RW -: RW];
   assign w_imm  = {{(ARQ-IMMW){1'b0}}, instr[IMMW-1:0]};
   assign w_addr = instr[AW-1:0];

`ifdef ID_WB_BYPASS_EN
   assign w_rs1_val = (wb_we && (wb_addr == w_rs1)) ? wb_data : r_regs[w_rs1];
   assign w_rs2_val = (wb_we && (wb_addr == w_rs2)) ? wb_data : r_regs[w_rs2];
`else
   assign w_rs1_val = r_regs[w_rs1];
   assign w_rs2_val = r_regs[w_rs2];
`endif

   // Opcode decode into control vector and source-usage flags
   always_comb begin
      w_ctl       = 9'b0;
      w_reads_rs1 = 1'b0;
      w_reads_rs2 = 1'b0;
      case (w_op)
         OP_SET: w_ctl = 9'b001000100;
         OP_ADD: begin w_ctl = 9'b000000101; w_reads_rs1 = 1'b1; w_reads_rs2 = 1'b1; end
         OP_SUB: begin w_ctl = 9'b000000110; w_reads_rs1 = 1'b1; w_reads_rs2 = 1'b1; end
         OP_CMP: begin w_ctl = 9'b000000011; w_reads_rs1 = 1'b1; w_reads_rs2 = 1'b1; end
         OP_LD:  begin w_ctl = 9'b100100100; w_reads_rs1 = 1'b1; end
         OP_ST:  begin w_ctl = 9'b010000000; w_reads_rs1 = 1'b1; w_reads_rs2 = 1'b1; end
         OP_JEQ: w_ctl = 9'b000010000;
         OP_J:   w_ctl = 9'b000011000;
         default: w_ctl = 9'b0;
      endcase
   end

   // A held load whose destination feeds the incoming instruction must drain first
   assign w_hazard = r_valid && r_is_ld &&
                     ((w_reads_rs1 && (r_rd == w_rs1)) || (w_reads_rs2 && (r_rd == w_rs2)));
   assign in_ready = (!r_valid || out_ready) && !w_hazard && !flush && !rst;
   assign w_take   = in_valid && in_ready;

   // Register file write port, cleared by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      end else if (wb_we) begin
         r_regs[wb_addr] <= wb_data;
      end
   end

   // Output bundle register: flush beats load, load beats drain, otherwise hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_is_ld <= 1'b0;
         r_a     <= '0;
         r_b     <= '0;
         r_imm   <= '0;
         r_addr  <= '0;
         r_rd    <= '0;
         r_ctl   <= '0;
      end else if (flush) begin
         r_valid <= 1'b0;
         r_is_ld <= 1'b0;
         r_ctl   <= '0;
      end else if (w_take) begin
         r_valid <= 1'b1;
         r_is_ld <= (w_op == OP_LD);
         r_a     <= w_rs1_val;
         r_b     <= w_rs2_val;
         r_imm   <= w_imm;
         r_addr  <= w_addr;
         r_rd    <= w_rd;
         r_ctl   <= w_ctl;
      end else if (out_ready) begin
         r_valid <= 1'b0;
         r_is_ld <= 1'b0;
         r_ctl   <= '0;
      end
   end

   assign out_valid = r_valid;
   assign out_a     = r_a;
   assign out_b     = r_b;
   assign out_imm   = r_imm;
   assign out_addr  = r_addr;
   assign out_rd    = r_rd;
   assign {rd_mem_en, wr_mem_en, mux_exe, mux_mem, jenable, jop_lsb, wb_enable, alu_op} = r_ctl;

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: randomized scoreboard bench for id_stage_pipe.
module tb_id_stage_pipe;
   localparam int ARQ   = 16;
   localparam int NREGS = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] instr = '0;
   logic        wb_we = 1'b0;
   logic [3:0]  wb_addr = '0;
   logic [15:0] wb_data = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_a, out_b, out_imm;
   logic [11:0] out_addr;
   logic [3:0]  out_rd;
   logic        rd_mem_en, wr_mem_en, mux_exe, mux_mem, jenable, jop_lsb, wb_enable;
   logic [1:0]  alu_op;
   logic [8:0]  ctl;

   always #5 clk = ~clk;

   id_stage_pipe #(.ARQ(ARQ), .NREGS(NREGS)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
      .out_imm(out_imm), .out_addr(out_addr), .out_rd(out_rd),
      .rd_mem_en(rd_mem_en), .wr_mem_en(wr_mem_en), .mux_exe(mux_exe), .mux_mem(mux_mem),
      .jenable(jenable), .jop_lsb(jop_lsb), .wb_enable(wb_enable), .alu_op(alu_op)
   );

   assign ctl = {rd_mem_en, wr_mem_en, mux_exe, mux_mem, jenable, jop_lsb, wb_enable, alu_op};

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] imm;
      logic [11:0] addr;
      logic [3:0]  rd;
      logic [8:0]  ctl;
   } bundle_t;

   bundle_t     sb[$];
   int          n_checks = 0;
   int          n_fail = 0;
   logic [15:0] m_regs [16];
   bit          m_valid = 0;
   bit          m_held_ld = 0;
   logic [3:0]  m_held_rd = '0;

   task automatic check(string name, logic [72:0] act, logic [72:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Control meaning per opcode, order rd_mem, wr_mem, mux_exe, mux_mem, jen, jlsb, wb, alu[1:0]
   function automatic logic [8:0] ctl_of(logic [3:0] op);
      case (op)
         4'd0: return 9'b001000100;
         4'd1: return 9'b000000101;
         4'd2: return 9'b000000110;
         4'd3: return 9'b000000011;
         4'd4: return 9'b100100100;
         4'd5: return 9'b010000000;
         4'd6: return 9'b000010000;
         4'd7: return 9'b000011000;
         default: return 9'b0;
      endcase
   endfunction

   function automatic logic [15:0] rd_op(logic [3:0] r, logic we, logic [3:0] wa, logic [15:0] wd);
`ifdef ID_WB_BYPASS_EN
      if (we && (wa == r)) return wd;
`endif
      return m_regs[r];
   endfunction

   // Drive one cycle (called at posedge+1), predict acceptance and the resulting bundle
   task automatic cycle(bit iv, logic [15:0] ins, bit we, logic [3:0] wa, logic [15:0] wd, bit fl, bit ordy);
      logic [3:0] op, rd, s1, s2;
      bit r1, r2, hz, rdy;
      bundle_t e;
      in_valid = iv; instr = ins; wb_we = we; wb_addr = wa; wb_data = wd; flush = fl; out_ready = ordy;
      op = ins[15:12]; rd = ins[11:8]; s1 = ins[7:4]; s2 = ins[3:0];
      r1 = (op >= 4'd1) && (op <= 4'd5);
      r2 = (op == 4'd1) || (op == 4'd2) || (op == 4'd3) || (op == 4'd5);
      hz = m_valid && m_held_ld && ((r1 && m_held_rd == s1) || (r2 && m_held_rd == s2));
      rdy = (!m_valid || ordy) && !hz && !fl;
      #1;
      check("in_ready", 73'(in_ready), 73'(rdy));
      if (fl) begin
         m_valid = 0; m_held_ld = 0;
      end else if (iv && rdy) begin
         e.a = rd_op(s1, we, wa, wd);
         e.b = rd_op(s2, we, wa, wd);
         e.imm = {8'd0, ins[7:0]};
         e.addr = ins[11:0];
         e.rd = rd;
         e.ctl = ctl_of(op);
         sb.push_back(e);
         m_valid = 1; m_held_ld = (op == 4'd4); m_held_rd = rd;
      end else if (ordy) begin
         m_valid = 0; m_held_ld = 0;
      end
      if (we) m_regs[wa] = wd;
      @(posedge clk); #1;
   endtask

   task automatic reset_mid();
      in_valid = 0; flush = 0; wb_we = 0; out_ready = 0;
      #2 rst = 1'b1;
      #1;
      check("rst_out_valid", 73'(out_valid), 73'd0);
      check("rst_ctl", 73'(ctl), 73'd0);
      check("rst_in_ready", 73'(in_ready), 73'd0);
      sb.delete();
      m_valid = 0; m_held_ld = 0;
      foreach (m_regs[i]) m_regs[i] = '0;
      @(posedge clk); @(posedge clk); #1 rst = 1'b0;
   endtask

   // Monitor: compare each consumed bundle with the oldest expected one
   initial begin
      bundle_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (out_valid) begin
               if (flush) begin
                  if (sb.size() > 0) e = sb.pop_front();
               end else if (out_ready) begin
                  if (sb.size() == 0) begin
                     n_checks++; n_fail++;
                     $display("FAIL bundle: out_valid=1 with no expected bundle at %0t", $time);
                  end else begin
                     e = sb.pop_front();
                     check("bundle", {out_a, out_b, out_imm, out_addr, out_rd, ctl}, e);
                  end
               end
            end else begin
               check("idle_ctl", 73'(ctl), 73'd0);
            end
         end
      end
   end

   initial begin
      logic [15:0] exp41;
      logic [3:0]  op;
      foreach (m_regs[i]) m_regs[i] = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_out_valid", 73'(out_valid), 73'd0);
      check("reset_in_ready", 73'(in_ready), 73'd0);
      check("reset_ctl", 73'(ctl), 73'd0);
      check("reset_out_a", 73'(out_a), 73'd0);
      @(posedge clk); #1 rst = 1'b0;

      // SET R2,16 right after reset
      cycle(1, 16'h0210, 0, 0, 0, 0, 1);
      check("set_valid", 73'(out_valid), 73'd1);
      check("set_rd", 73'(out_rd), 73'd2);
      check("set_imm", 73'(out_imm), 73'd16);
      check("set_ctl", 73'(ctl), 73'b001000100);

      // write R1=451 while decoding ADD R3,R1,R1
      cycle(1, 16'h1311, 1, 4'd1, 16'd451, 0, 1);
`ifdef ID_WB_BYPASS_EN
      exp41 = 16'd451;
`else
      exp41 = 16'd0;
`endif
      check("wb_same_cycle_a", 73'(out_a), 73'(exp41));

      // load-use: LD R4,[R2] then ADD R5,R4,R1
      cycle(1, 16'h4420, 0, 0, 0, 0, 1);
      check("ld_rd_mem", 73'(rd_mem_en), 73'd1);
      cycle(1, 16'h1541, 0, 0, 0, 0, 1);
      check("bubble", 73'(out_valid), 73'd0);
      cycle(1, 16'h1541, 0, 0, 0, 0, 1);
      check("after_bubble_valid", 73'(out_valid), 73'd1);
      check("after_bubble_rd", 73'(out_rd), 73'd5);

      // J 5 held for three stalled cycles
      cycle(1, 16'h7005, 0, 0, 0, 0, 1);
      for (int k = 0; k < 3; k++) begin
         cycle(1, 16'h0333, 0, 0, 0, 0, 0);
         check("stall_jump_ctl", 73'({jenable, jop_lsb}), 73'b11);
         check("stall_addr", 73'(out_addr), 73'd5);
         check("stall_in_ready", 73'(in_ready), 73'd0);
      end
      cycle(0, 16'h0000, 0, 0, 0, 0, 1);

      // flush with a held bundle and a pending instruction
      cycle(1, 16'h0107, 0, 0, 0, 0, 1);
      check("pre_flush_valid", 73'(out_valid), 73'd1);
      cycle(1, 16'h0208, 0, 0, 0, 1, 0);
      check("flush_valid", 73'(out_valid), 73'd0);
      cycle(0, 16'h0000, 0, 0, 0, 0, 1);

      // randomized traffic, small register range to provoke interlocks
      for (int n = 0; n < 1500; n++) begin
         bit fl;
         op = 4'($urandom_range(0, 15));
         fl = ($urandom_range(0, 15) == 0);
         cycle($urandom_range(0, 3) != 0,
               {op, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))},
               $urandom_range(0, 1) == 1, 4'($urandom_range(0, 3)), 16'($urandom),
               fl, fl ? 1'b0 : ($urandom_range(0, 3) != 0));
      end

      // asynchronous reset with a bundle held
      cycle(1, 16'h0305, 0, 0, 0, 0, 0);
      check("pre_rst_valid", 73'(out_valid), 73'd1);
      reset_mid();
      cycle(1, 16'h1312, 0, 0, 0, 0, 1);
      check("post_rst_regs_a", 73'(out_a), 73'd0);
      check("post_rst_regs_b", 73'(out_b), 73'd0);

      for (int n = 0; n < 500; n++) begin
         bit fl;
         op = 4'($urandom_range(0, 15));
         fl = ($urandom_range(0, 15) == 0);
         cycle($urandom_range(0, 3) != 0,
               {op, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))},
               $urandom_range(0, 1) == 1, 4'($urandom_range(0, 3)), 16'($urandom),
               fl, fl ? 1'b0 : ($urandom_range(0, 3) != 0));
      end

      repeat (3) cycle(0, 16'h0000, 0, 0, 0, 0, 1);
      check("drain_empty", 73'(sb.size()), 73'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
